cache_ctrl_burst: RTL and testbench

Parametrised successor to the single-word cache controller FSM. It sequences CPU read and write requests against a direct-mapped cache and a slow main memory. It adds multi-word line fills, a configurable internal memory wait-state counter and an optional write-allocate policy. It sits between the CPU strobe/ready handshake and the cache data array, tag compare and memory bus.

---
 rtl/cache_ctrl_burst.sv | 161 ++++++++++++++++
 tb/tb_cache_ctrl_burst.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_burst.sv
// cache_ctrl_burst
//   Sequences CPU read/write requests against a direct-mapped cache and a slow
//   main memory. Line fills are multi-word, memory wait states are counted
//   internally, and writes are always written through to memory.
//
//   Optional feature macro: CACHE_WRITE_ALLOCATE_EN
//     defined   - a write miss fills the line, writes the CPU word into the
//                 array, then writes through to memory.
//     undefined - a write miss goes straight to the memory write
//                 (no-write-allocate).
//
// Parameters
//   WAIT_CYCLES  memory wait states per word access (>= 1)
//   LINE_WORDS   words per cache line (power of 2, >= 1)
//   IDX_W        width of WordIdx
//
// Ports
//   clk      clock, rising edge
//   reset    synchronous active-high reset
//   Strobe   CPU request, sampled in IDLE only
//   DRW      CPU direction, 1 = read / 0 = write, sampled with Strobe
//   M, V     tag match / line valid, sampled in the CHK states
//   DReady   CPU transaction complete, one cycle per request
//   W        cache data array write enable
//   MStrobe  memory access start, one-cycle pulse per word
//   MRW      memory direction, 1 = read / 0 = write
//   RSel     CPU read mux, 0 = cache array / 1 = memory data register
//   WSel     array write mux, 0 = CPU data / 1 = memory data
//   WordIdx  word offset within the line during a fill
module cache_ctrl_burst #(
  parameter int WAIT_CYCLES = 4,
  parameter int LINE_WORDS  = 4,
  parameter int IDX_W       = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Strobe,
  input  logic             DRW,
  input  logic             M,
  input  logic             V,
  output logic             DReady,
  output logic             W,
  output logic             MStrobe,
  output logic             MRW,
  output logic             RSel,
  output logic             WSel,
  output logic [IDX_W-1:0] WordIdx
);

  localparam int               CNT_W    = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WLOAD    = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [3:0] {
    IDLE, RD_CHK, RD_DONE, WR_CHK, WR_HIT, WR_REQ, WR_WAIT, WR_DONE,
    FILL_REQ, FILL_WAIT, FILL_WR
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wcnt;
  logic [IDX_W-1:0] word_idx;
  logic             op_wr;   // current fill is on behalf of a write
  logic             hit;

  assign hit     = M & V;
  assign WordIdx = word_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wcnt     <= '0;
      word_idx <= '0;
      op_wr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Strobe) begin
            state <= DRW ? RD_CHK : WR_CHK;
`ifdef CACHE_WRITE_ALLOCATE_EN
            op_wr <= ~DRW;
`endif
          end
        end
        RD_CHK: begin
          if (hit) begin
            state <= IDLE;
          end else begin
            word_idx <= '0;
            state    <= FILL_REQ;
          end
        end
        FILL_REQ: begin
          wcnt  <= WLOAD;
          state <= FILL_WAIT;
        end
        // The cycle that sees wcnt==0 is the last wait cycle; holding at 0
        // keeps the counter from wrapping.
        FILL_WAIT: begin
          if (wcnt == '0) state <= FILL_WR;
          else            wcnt  <= wcnt - 1'b1;
        end
        FILL_WR: begin
          if (word_idx == LAST_IDX) begin
            word_idx <= '0;
            state    <= op_wr ? WR_HIT : RD_DONE;
          end else begin
            word_idx <= word_idx + 1'b1;
            state    <= FILL_REQ;
          end
        end
        RD_DONE: state <= IDLE;
        WR_CHK: begin
          if (hit) begin
            state <= WR_REQ;
          end else begin
`ifdef CACHE_WRITE_ALLOCATE_EN
            word_idx <= '0;
            state    <= FILL_REQ;
`else
            state    <= WR_REQ;
`endif
          end
        end
        WR_HIT: state <= WR_REQ;
        WR_REQ: begin
          wcnt  <= WLOAD;
          state <= WR_WAIT;
        end
        WR_WAIT: begin
          if (wcnt == '0) state <= WR_DONE;
          else            wcnt  <= wcnt - 1'b1;
        end
        WR_DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode; only the CHK states look at the live M&V.
  always_comb begin
    DReady  = 1'b0;
    W       = 1'b0;
    MStrobe = 1'b0;
    MRW     = 1'b0;
    RSel    = 1'b0;
    WSel    = 1'b0;
    case (state)
      RD_CHK:    DReady = hit;
      FILL_REQ:  begin MStrobe = 1'b1; MRW = 1'b1; end
      FILL_WAIT: MRW = 1'b1;
      FILL_WR:   begin W = 1'b1; WSel = 1'b1; end
      RD_DONE:   begin DReady = 1'b1; RSel = 1'b1; end
      WR_CHK:    W = hit;
      WR_HIT:    W = 1'b1;
      WR_REQ:    MStrobe = 1'b1;
      WR_DONE:   DReady = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl_burst.sv
// Testbench for cache_ctrl_burst (default parameters). Each request pushes its
// expected output events (cycle, flags, WordIdx) into a queue; a negedge
// monitor pops and compares whenever DReady, W or MStrobe is high.
module tb_cache_ctrl_burst;

  logic       clk = 1'b0;
  logic       reset, Strobe, DRW, M, V;
  logic       DReady, W, MStrobe, MRW, RSel, WSel;
  logic [1:0] WordIdx;
  logic [5:0] fo;

  cache_ctrl_burst dut (
    .clk(clk), .reset(reset), .Strobe(Strobe), .DRW(DRW), .M(M), .V(V),
    .DReady(DReady), .W(W), .MStrobe(MStrobe), .MRW(MRW), .RSel(RSel),
    .WSel(WSel), .WordIdx(WordIdx)
  );

  always #5 clk = ~clk;

  assign fo = {DReady, W, MStrobe, MRW, RSel, WSel};

  // flag order: DReady W MStrobe MRW RSel WSel
  localparam logic [5:0] F_RHIT  = 6'b100000;
  localparam logic [5:0] F_MRD   = 6'b001100;
  localparam logic [5:0] F_FILLW = 6'b010001;
  localparam logic [5:0] F_RDONE = 6'b100010;
  localparam logic [5:0] F_WARR  = 6'b010000;
  localparam logic [5:0] F_MWR   = 6'b001000;
  localparam logic [5:0] F_WDONE = 6'b100000;

  typedef struct {
    int         cyc;
    logic [5:0] f;
    logic [1:0] idx;
  } ev_t;

  ev_t q[$];
  int  cyc   = 0;
  int  total = 0;
  int  bad   = 0;
  int  t0    = 0;
  bit  en    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  always @(negedge clk) begin
    ev_t e;
    if (en) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        total++; bad++;
        $display("FAIL missed_event: expected f=%b idx=%0d at cyc %0d, absent through cyc %0d",
                 e.f, e.idx, e.cyc, cyc);
      end
      if (DReady | W | MStrobe) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL extra_event: cyc %0d got f=%b idx=%0d, expected no event",
                   cyc, fo, WordIdx);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.f !== fo || e.idx !== WordIdx) begin
            bad++;
            $display("FAIL event: got cyc %0d f=%b idx=%0d, expected cyc %0d f=%b idx=%0d",
                     cyc, fo, WordIdx, e.cyc, e.f, e.idx);
          end
        end
      end
    end
  end

  task automatic push(input int rel, input logic [5:0] f, input logic [1:0] idx);
    ev_t e;
    e.cyc = t0 + rel;
    e.f   = f;
    e.idx = idx;
    q.push_back(e);
  endtask

  // Full 4-word line fill starting at relative cycle base; 6 cycles per word.
  task automatic push_fill(input int base);
    for (int k = 0; k < 4; k++) begin
      push(base + 6*k,     F_MRD,   2'(k));
      push(base + 5 + 6*k, F_FILLW, 2'(k));
    end
  endtask

  task automatic check_vec(input string name, input logic [7:0] exp);
    total++;
    if ({fo, WordIdx} !== exp) begin
      bad++;
      $display("FAIL %s: got %b, expected %b", name, {fo, WordIdx}, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  task automatic txn(input bit drw, input bit m, input bit v);
    int d;
    t0 = cyc;
    Strobe = 1'b1; DRW = drw; M = m; V = v;
    if (drw) begin
      if (m & v) begin
        push(1, F_RHIT, 2'd0); d = 1;
      end else begin
        push_fill(2); push(26, F_RDONE, 2'd0); d = 26;
      end
    end else begin
      if (m & v) begin
        push(1, F_WARR, 2'd0); push(2, F_MWR, 2'd0); push(7, F_WDONE, 2'd0); d = 7;
      end else begin
`ifdef CACHE_WRITE_ALLOCATE_EN
        push_fill(2);
        push(26, F_WARR, 2'd0); push(27, F_MWR, 2'd0); push(32, F_WDONE, 2'd0); d = 32;
`else
        push(2, F_MWR, 2'd0); push(7, F_WDONE, 2'd0); d = 7;
`endif
      end
    end
    @(negedge clk);
    Strobe = 1'b0;
    repeat (d) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; Strobe = 1'b1; DRW = 1'b1; M = 1'b1; V = 1'b1;
    // Reset held with Strobe high: nothing may happen.
    repeat (3) begin
      @(negedge clk);
      check_vec("reset_hold", 8'h00);
    end
    // Request already pending starts as soon as reset drops.
    en = 1'b1;
    t0 = cyc;
    push(1, F_RHIT, 2'd0);
    reset = 1'b0;
    @(negedge clk);
    Strobe = 1'b0;
    @(negedge clk);

    txn(1'b1, 1'b1, 1'b1);   // read hit
    txn(1'b1, 1'b1, 1'b0);   // read miss, invalid line
    txn(1'b0, 1'b1, 1'b1);   // write hit
    txn(1'b0, 1'b0, 1'b1);   // write miss
    txn(1'b1, 1'b0, 1'b1);   // read miss, tag mismatch

    // Reset during FILL_WAIT of word 2.
    t0 = cyc;
    Strobe = 1'b1; DRW = 1'b1; M = 1'b0; V = 1'b0;
    push(2, F_MRD, 2'd0); push(7, F_FILLW, 2'd0);
    push(8, F_MRD, 2'd1); push(13, F_FILLW, 2'd1);
    push(14, F_MRD, 2'd2);
    @(negedge clk);
    Strobe = 1'b0;
    repeat (15) @(negedge clk);
    check_vec("fill_wait_word2", {6'b000100, 2'd2});
    reset = 1'b1;
    @(negedge clk);
    check_vec("reset_midfill", 8'h00);
    reset = 1'b0;
    txn(1'b1, 1'b1, 1'b1);   // read hit after reset

    repeat (10) @(negedge clk);
    while (q.size() > 0) begin
      ev_t e;
      e = q.pop_front();
      total++; bad++;
      $display("FAIL leftover_event: expected f=%b idx=%0d at cyc %0d never seen",
               e.f, e.idx, e.cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
